sram_burst_controller: RTL and testbench
========================================

# sram_burst_controller

Parametrised successor to the memory-stage SRAM controller: it splits one DATA_W-bit CPU access into DATA_W/16 consecutive 16-bit SRAM beats. Each beat lasts a programmable number of wait cycles, and writes can be masked per byte. It sits between the MEM stage and the off-chip 16-bit asynchronous SRAM. Its `ready` output freezes the pipeline while a transaction is in flight.

## Interface
- DATA_W, 32: CPU data width; multiple of 16, ≥16; BEATS = DATA_W/16.
- ADDR_W, 32: CPU byte-address width.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 1: extra cycles per beat, ≥1; beat length L = WAIT_CYCLES+1.

Ports:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request; held by MEM until `ready` is seen high.
- wr_en  in  1  write request; same hold rule as rd_en.
- addr  in  ADDR_W  byte address.
- write_data  in  DATA_W  store data.
- byte_en  in  DATA_W/8  write byte mask, bit k enables byte k.
- read_data  out  DATA_W  load data; registered.
- ready  out  1  high = MEM stage may advance.
- SRAM_DQ  inout  16  data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  registered.
- SRAM_LB_N, SRAM_UB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  active-low controls; all registered.

## Operation
- States:
  - IDLE → ACCESS on the edge where rd_en|wr_en is seen.
  - ACCESS → DONE after the final cycle of beat BEATS-1.
  - DONE → IDLE unconditionally.
- Request priority: rd_en wins when both rd_en and wr_en are high.
- Latching at accept: addr, write_data, byte_en and the op type are captured. Input changes during ACCESS/DONE are ignored.
- Base address: base = {addr[SRAM_ADDR_W:1] with the low log2(BEATS) bits forced to 0}. Misaligned addresses are silently aligned.
- Beat i (0..BEATS-1):
  - SRAM_ADDR = base+i, wrapping modulo 2^SRAM_ADDR_W.
  - Lowest half-word goes first.
- Wait counter: runs 0..L-1 within each beat. The beat counter advances when the wait counter reaches L-1.
- Write beat:
  - SRAM_DQ driven with write_data[16i+15:16i] for all L cycles.
  - SRAM_WE_N = 0 for wait counts 0..L-2 and 1 on count L-1, giving address/data hold.
  - LB_N = ~byte_en[2i], UB_N = ~byte_en[2i+1].
  - OE_N = 1.
  - A beat with both byte enables 0 still spends L cycles and WE_N still pulses; the SRAM ignores it.
- Read beat:
  - OE_N = 0, WE_N = 1, LB_N = UB_N = 0, SRAM_DQ = Z.
  - read_data[16i+15:16i] is captured from SRAM_DQ on the edge ending wait count L-1.
- read_data updates only on read beats and otherwise holds its value.
- SRAM_CE_N = 0 in ACCESS only; it is 1 in IDLE and DONE.
- ready (combinational from state):
  - 1 in DONE.
  - 1 in IDLE with no request.
  - 0 otherwise, including IDLE with a request present.
- A request still high in the IDLE cycle after DONE starts a new transaction.

## Timing
- Reset values:
  - state IDLE, counters 0.
  - read_data = 0, SRAM_ADDR = 0.
  - WE_N = OE_N = CE_N = LB_N = UB_N = 1.
  - DQ released (Z).
  - ready = 0 while rst is high.
- Latency: accept edge, then BEATS·L cycles of ACCESS, then 1 DONE cycle. With defaults, a request seen in cycle 0 gives ready = 1 in cycle 5.
- SRAM outputs for beat 0 are valid in the cycle after accept; no combinational path from rd_en/wr_en to the SRAM pins.
- DQ is driven only while the registered write-beat flag is set. It turns around to Z on the edge into DONE, and a read never drives DQ.
- Reset mid-ACCESS: all outputs return to reset values on that edge. A partially written word is permitted; no completion is signalled.
- Back-to-back transactions: minimum one IDLE cycle between DONE and the next ACCESS.

## Structure
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the constant HALF_W = 16;
  - a function for beat count and counter widths ($clog2).
- One sub-module, sram_beat_timer: the wait and beat counters, with outputs beat_idx, beat_last_cycle and xfer_last.
- FSM, latches and pin registers stay in sram_burst_controller.

## Test plan
- Reset pins: assert rst for 3 cycles with rd_en = 1 → ready = 0, CE_N = WE_N = OE_N = 1, DQ = Z, read_data = 0.
- Full write: defaults, write 0xDEADBEEF to addr 0x40, byte_en = 0xF:
  - beat 0: SRAM_ADDR 0x20, DQ 0xBEEF, WE_N low for 1 cycle;
  - beat 1: SRAM_ADDR 0x21, DQ 0xDEAD;
  - ready high 5 cycles after the request.
- Read back: model returns 0xBEEF / 0xDEAD → read_data = 0xDEADBEEF in DONE; OE_N low for 4 cycles; DQ never driven.
- Masked write: byte_en = 0b0110, data 0x11223344 → beat 0 LB_N = 1, UB_N = 0; beat 1 LB_N = 0, UB_N = 1; model memory shows only bytes 0x22 and 0x33 changed.
- Parameter sweep: DATA_W = 64, WAIT_CYCLES = 3, addr 0x7 → base aligned to 0x0, 4 beats × 4 cycles, ready in cycle 17; top-address wrap checked at base 0x3FFFC.
- Edge cases:
  - rd_en and wr_en together → read performed;
  - rst asserted during beat 1 → WE_N = 1 and DQ = Z on the next edge, then FSM in IDLE.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared state type and sizing helpers for the 16-bit burst SRAM controller.
package sram_ctrl_pkg;

    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int beat_count(input int data_w);
        return data_w / HALF_W;
    endfunction

    // Counter width that stays at least one bit for single-value ranges.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-cycle and beat counters for one burst; held at zero whenever run is low.
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int BEATS    = 2,
    parameter int BEAT_LEN = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    output logic [cnt_w(BEATS)-1:0]     beat_idx,
    output logic [cnt_w(BEAT_LEN)-1:0]  wait_cnt,
    output logic                        beat_last_cycle,
    output logic                        xfer_last
);

    localparam int BW = cnt_w(BEATS);
    localparam int WW = cnt_w(BEAT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(BEAT_LEN - 1);

    assign beat_last_cycle = run && (wait_cnt == LAST_WAIT);
    assign xfer_last       = beat_last_cycle && (beat_idx == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            wait_cnt <= '0;
            beat_idx <= '0;
        end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_burst_controller.sv
// Splits one DATA_W-bit CPU access into DATA_W/16 timed beats on a 16-bit async SRAM.
// state  | meaning
// IDLE   | waiting for rd_en/wr_en; request latched on the accept edge
// ACCESS | running BEATS beats of WAIT_CYCLES+1 cycles each, CE_N low
// DONE   | one-cycle completion, ready high, bus released
module sram_burst_controller
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       write_data,
    input  logic [DATA_W/8-1:0]     byte_en,
    output logic [DATA_W-1:0]       read_data,
    output logic                    ready,
    inout  wire  [HALF_W-1:0]       SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0]  SRAM_ADDR,
    output logic                    SRAM_LB_N,
    output logic                    SRAM_UB_N,
    output logic                    SRAM_WE_N,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_OE_N
);

    localparam int BEATS      = beat_count(DATA_W);
    localparam int BEAT_LEN   = WAIT_CYCLES + 1;
    localparam int BE_W       = DATA_W / 8;
    localparam int BW         = cnt_w(BEATS);
    localparam int WW         = cnt_w(BEAT_LEN);
    localparam int ALIGN_BITS = $clog2(BEATS);
    localparam logic [SRAM_ADDR_W-1:0] ALIGN_MASK    = ~SRAM_ADDR_W'((1 << ALIGN_BITS) - 1);
    localparam logic [WW-1:0]          PRE_LAST_WAIT = WW'(BEAT_LEN - 2);

    state_t                   state;
    logic                     op_read;
    logic [DATA_W-1:0]        wdata_q;
    logic [BE_W-1:0]          be_q;
    logic [HALF_W-1:0]        dq_out;
    logic                     dq_oe;
    logic [BW-1:0]            beat_idx;
    logic [WW-1:0]            wait_cnt;
    logic                     beat_last_cycle;
    logic                     xfer_last;
    logic                     request;
    logic [SRAM_ADDR_W-1:0]   base;
    logic                     unused_addr;

    assign request     = rd_en | wr_en;
    assign base        = addr[SRAM_ADDR_W:1] & ALIGN_MASK;
    assign unused_addr = ^{addr[ADDR_W-1:SRAM_ADDR_W+1], addr[0]};
    assign ready       = !rst && ((state == DONE) || ((state == IDLE) && !request));
    assign SRAM_DQ     = dq_oe ? dq_out : {HALF_W{1'bz}};

    sram_beat_timer #(
        .BEATS    (BEATS),
        .BEAT_LEN (BEAT_LEN)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .run             (state == ACCESS),
        .beat_idx        (beat_idx),
        .wait_cnt        (wait_cnt),
        .beat_last_cycle (beat_last_cycle),
        .xfer_last       (xfer_last)
    );

    // Pins are registered one cycle ahead: each branch sets what the next cycle shows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_read   <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state     <= ACCESS;
                        op_read   <= rd_en;
                        wdata_q   <= write_data >> HALF_W;
                        be_q      <= byte_en >> 2;
                        dq_out    <= write_data[HALF_W-1:0];
                        dq_oe     <= !rd_en;
                        SRAM_ADDR <= base;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= !rd_en;
                        SRAM_WE_N <= rd_en;
                        SRAM_LB_N <= !rd_en && !byte_en[0];
                        SRAM_UB_N <= !rd_en && !byte_en[1];
                    end
                end
                ACCESS: begin
                    if (beat_last_cycle && op_read) begin
                        read_data[HALF_W*beat_idx +: HALF_W] <= SRAM_DQ;
                    end
                    if (xfer_last) begin
                        state     <= DONE;
                        dq_oe     <= 1'b0;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                    end else if (beat_last_cycle) begin
                        SRAM_ADDR <= SRAM_ADDR + 1'b1;
                        dq_out    <= wdata_q[HALF_W-1:0];
                        wdata_q   <= wdata_q >> HALF_W;
                        be_q      <= be_q >> 2;
                        SRAM_WE_N <= op_read;
                        SRAM_LB_N <= !op_read && !be_q[0];
                        SRAM_UB_N <= !op_read && !be_q[1];
                    end else if (wait_cnt == PRE_LAST_WAIT) begin
                        // WE_N rises for the final cycle so address/data are held past it.
                        SRAM_WE_N <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Randomized bench for sram_burst_controller: default and 64-bit/3-wait instances share one SRAM model.
module tb_sram_burst_controller;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        sel   = 1'b0;
    logic        rd_en = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] addr  = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be    = '0;

    always #5 clk = ~clk;

    logic [31:0] rd0;
    logic [63:0] rd1;
    logic        ready0, ready1;
    logic [17:0] sa0, sa1;
    logic        lb0, ub0, we0, ce0, oe0;
    logic        lb1, ub1, we1, ce1, oe1;
    wire  [15:0] dq0, dq1;
    logic [15:0] rd_val0 = '0;
    logic [15:0] rd_val1 = '0;

    sram_burst_controller u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en & ~sel),
        .wr_en      (wr_en & ~sel),
        .addr       (addr),
        .write_data (wdata[31:0]),
        .byte_en    (be[3:0]),
        .read_data  (rd0),
        .ready      (ready0),
        .SRAM_DQ    (dq0),
        .SRAM_ADDR  (sa0),
        .SRAM_LB_N  (lb0),
        .SRAM_UB_N  (ub0),
        .SRAM_WE_N  (we0),
        .SRAM_CE_N  (ce0),
        .SRAM_OE_N  (oe0)
    );

    sram_burst_controller #(
        .DATA_W      (64),
        .WAIT_CYCLES (3)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en & sel),
        .wr_en      (wr_en & sel),
        .addr       (addr),
        .write_data (wdata),
        .byte_en    (be),
        .read_data  (rd1),
        .ready      (ready1),
        .SRAM_DQ    (dq1),
        .SRAM_ADDR  (sa1),
        .SRAM_LB_N  (lb1),
        .SRAM_UB_N  (ub1),
        .SRAM_WE_N  (we1),
        .SRAM_CE_N  (ce1),
        .SRAM_OE_N  (oe1)
    );

    // Released bus reads as all ones.
    for (genvar k = 0; k < 16; k++) begin : g_pull
        pullup (dq0[k]);
        pullup (dq1[k]);
    end

    assign dq0 = (!ce0 && !oe0) ? rd_val0 : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1) ? rd_val1 : 16'hzzzz;

    logic        ready_m;
    logic [63:0] rdata_m;
    logic [17:0] sa_m;
    logic [15:0] dq_m;
    logic [4:0]  ctl_m;

    assign ready_m = sel ? ready1 : ready0;
    assign rdata_m = sel ? rd1 : {32'h0, rd0};
    assign sa_m    = sel ? sa1 : sa0;
    assign dq_m    = sel ? dq1 : dq0;
    assign ctl_m   = sel ? {ce1, oe1, we1, lb1, ub1} : {ce0, oe0, we0, lb0, ub0};

    logic [15:0] sram_mem [int];
    logic [15:0] ref_mem  [int];
    logic [63:0] prev_rd  [2];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [15:0] init_half(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] sram_rd(input int a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return init_half(a);
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_half(a);
    endfunction

    task automatic sram_wr(input int a, input logic [15:0] d, input logic lb_n, input logic ub_n);
        logic [15:0] h;
        h = sram_rd(a);
        if (!lb_n) h[7:0]  = d[7:0];
        if (!ub_n) h[15:8] = d[15:8];
        sram_mem[a] = h;
    endtask

    always @(posedge clk) begin
        if (!ce0 && !we0) sram_wr(int'(sa0), dq0, lb0, ub0);
        if (!ce1 && !we1) sram_wr(int'(sa1), dq1, lb1, ub1);
    end

    always @(negedge clk) begin
        rd_val0 <= sram_rd(int'(sa0));
        rd_val1 <= sram_rd(int'(sa1));
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on instance s; inputs are scrambled once accepted.
    task automatic run_txn(input bit s, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [63:0] wd, input logic [7:0] bel);
        int          beats, len, base, cyc, beat, w, ha;
        logic [63:0] exp_rd;
        logic [4:0]  ctl_exp;
        logic [15:0] h;
        beats = s ? 4 : 2;
        len   = s ? 4 : 2;
        base  = int'((a >> 1) & 32'h3FFFF) & ~(beats - 1);
        sel = s; rd_en = rd; wr_en = wr; addr = a; wdata = wd; be = bel;
        #1;
        check_val("req_not_ready", 64'(ready_m), 64'd0);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready_m) break;
            if (cyc <= beats * len) begin
                beat = (cyc - 1) / len;
                w    = (cyc - 1) % len;
                ha   = (base + beat) & 32'h3FFFF;
                check_val("beat_addr", 64'(sa_m), 64'(ha));
                if (rd) ctl_exp = 5'b00100;
                else    ctl_exp = {1'b0, 1'b1, w == len - 1, ~bel[2*beat], ~bel[2*beat+1]};
                check_val("beat_ctl", 64'(ctl_m), 64'(ctl_exp));
                if (!rd) check_val("beat_dq", 64'(dq_m), 64'(wd[16*beat +: 16]));
            end
            addr = $urandom; wdata = {$urandom, $urandom}; be = 8'($urandom);
        end
        check_val("latency", 64'(cyc), 64'(1 + beats * len));
        check_val("done_dq_released", 64'(dq_m), 64'hFFFF);
        exp_rd = '0;
        for (int i = 0; i < beats; i++) exp_rd[16*i +: 16] = ref_rd((base + i) & 32'h3FFFF);
        if (rd) begin
            check_val("read_data", rdata_m, exp_rd);
            prev_rd[s] = exp_rd;
        end else begin
            check_val("read_data_hold", rdata_m, prev_rd[s]);
            for (int i = 0; i < beats; i++) begin
                ha = (base + i) & 32'h3FFFF;
                h  = ref_rd(ha);
                if (bel[2*i])   h[7:0]  = wd[16*i +: 8];
                if (bel[2*i+1]) h[15:8] = wd[16*i+8 +: 8];
                ref_mem[ha] = h;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check_val("idle_after_done", {62'h0, ready_m, ctl_m[4]}, 64'h3);
        if (!rd) begin
            for (int i = 0; i < beats; i++) begin
                ha = (base + i) & 32'h3FFFF;
                check_val("mem_word", 64'(sram_rd(ha)), 64'(ref_rd(ha)));
            end
        end
    endtask

    initial begin
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_ready", 64'(ready_m), 64'd0);
            check_val("rst_ctl", 64'(ctl_m), 64'h1F);
            check_val("rst_dq", 64'(dq_m), 64'hFFFF);
            check_val("rst_rdata", rdata_m, 64'd0);
            check_val("rst_addr", 64'(sa_m), 64'd0);
        end
        rst = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check_val("idle_ready", 64'(ready_m), 64'd1);

        run_txn(1'b0, 1'b0, 1'b1, 32'h40, 64'hDEADBEEF, 8'hF);
        check_val("wr_lo", 64'(sram_rd(32'h20)), 64'hBEEF);
        check_val("wr_hi", 64'(sram_rd(32'h21)), 64'hDEAD);
        run_txn(1'b0, 1'b1, 1'b0, 32'h40, 64'h0, 8'h0);
        check_val("readback", rdata_m, 64'hDEADBEEF);
        run_txn(1'b0, 1'b0, 1'b1, 32'h40, 64'h11223344, 8'b0110);
        check_val("masked_lo", 64'(sram_rd(32'h20)), 64'h33EF);
        check_val("masked_hi", 64'(sram_rd(32'h21)), 64'hDE22);
        run_txn(1'b0, 1'b1, 1'b1, 32'h40, 64'hFFFFFFFF, 8'hF);
        check_val("rd_wins", rdata_m, 64'hDE2233EF);
        check_val("rd_wins_mem", 64'(sram_rd(32'h20)), 64'h33EF);

        run_txn(1'b1, 1'b0, 1'b1, 32'h7, 64'h0123456789ABCDEF, 8'hFF);
        check_val("wide_beat0", 64'(sram_rd(0)), 64'hCDEF);
        check_val("wide_beat3", 64'(sram_rd(3)), 64'h0123);
        run_txn(1'b1, 1'b1, 1'b0, 32'h7, 64'h0, 8'h0);
        check_val("wide_readback", rdata_m, 64'h0123456789ABCDEF);
        run_txn(1'b1, 1'b0, 1'b1, 32'h7FFF8, {$urandom, $urandom}, 8'hFF);
        run_txn(1'b1, 1'b1, 1'b0, 32'h7FFFF, 64'h0, 8'h0);
        run_txn(1'b0, 1'b0, 1'b1, 32'h7FFFC, 64'($urandom), 8'hF);
        run_txn(1'b0, 1'b1, 1'b0, 32'h7FFFD, 64'h0, 8'h0);

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 2);
            run_txn(1'($urandom_range(0, 1)), op != 1, op != 0, 32'($urandom_range(0, 1023)),
                    {$urandom, $urandom}, 8'($urandom));
        end

        // Reset in the first cycle of beat 1 of a write.
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b1; addr = 32'h800; wdata = 64'hCAFEF00D; be = 8'hF;
        repeat (3) @(negedge clk);
        check_val("mid_beat1_addr", 64'(sa_m), 64'h401);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_ctl", 64'(ctl_m), 64'h1F);
        check_val("mid_rst_dq", 64'(dq_m), 64'hFFFF);
        check_val("mid_rst_ready", 64'(ready_m), 64'd0);
        check_val("mid_rst_addr", 64'(sa_m), 64'd0);
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check_val("mid_rst_idle", 64'(ready_m), 64'd1);
        check_val("mid_rst_rdata", rdata_m, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
